// File: rtl/fetch_ctrl_pkg.sv
// Shared hart fetch definitions: state encodings that hazard and trace logic decode too.
package fetch_ctrl_pkg;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;

  localparam logic [2:0] FETCH_ST_IDLE    = 3'd0;
  localparam logic [2:0] FETCH_ST_REQ     = 3'd1;
  localparam logic [2:0] FETCH_ST_WAIT    = 3'd2;
  localparam logic [2:0] FETCH_ST_DISCARD = 3'd3;
  localparam logic [2:0] FETCH_ST_VALID   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = FETCH_ST_IDLE,
    ST_REQ     = FETCH_ST_REQ,
    ST_WAIT    = FETCH_ST_WAIT,
    ST_DISCARD = FETCH_ST_DISCARD,
    ST_VALID   = FETCH_ST_VALID
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// PC/fetch sequencer: one outstanding I-cache request, stale-response discard on redirect,
// valid/ready handoff of the fetched word to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc,
  input  logic             trap,
  input  logic             pr_miss,
  input  logic             jalr_taken,
  output logic             pc_stall,
  output logic             ic_req,
  output logic [XLEN-1:0]  ic_addr,
  input  logic             ic_gnt,
  input  logic             ic_rvalid,
  input  logic [ILEN-1:0]  ic_rdata,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic [ILEN-1:0]  if_ins,
  input  logic             id_ready
);

  fetch_state_e    state;
  logic [XLEN-1:0] req_pc;
  logic            redirect;

  assign redirect = trap | pr_miss | jalr_taken;

  // The request address follows pc until granted, so a redirect before grant
  // simply retargets the pending request.
  assign ic_req   = (state == ST_REQ);
  assign ic_addr  = {pc[XLEN-1:1], 1'b0};
  assign pc_stall = !((state == ST_VALID) && id_ready);
  assign if_valid = (state == ST_VALID);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the output buffer shares this block with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      req_pc <= '0;
      if_pc  <= '0;
      if_ins <= '0;
    end else begin
      unique case (state)
        ST_IDLE: state <= ST_REQ;

        ST_REQ: begin
          if (ic_gnt) begin
            if (redirect) begin
              state <= ST_DISCARD;
            end else begin
              req_pc <= pc;
              state  <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (ic_rvalid) begin
            if (redirect) begin
              state <= ST_REQ;
            end else begin
              if_ins <= ic_rdata;
              if_pc  <= req_pc;
              state  <= ST_VALID;
            end
          end else if (redirect) begin
            state <= ST_DISCARD;
          end
        end

        // The response still owed by the I-cache must be absorbed before a new
        // request, otherwise it would be mistaken for the new PC's data.
        ST_DISCARD: begin
          if (ic_rvalid) state <= ST_REQ;
        end

        ST_VALID: begin
          if (redirect || id_ready) state <= ST_REQ;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: reset, handoff, backpressure, redirects, mid-fetch reset.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc;
  logic        trap, pr_miss, jalr_taken;
  logic        pc_stall;
  logic        ic_req;
  logic [63:0] ic_addr;
  logic        ic_gnt, ic_rvalid;
  logic [31:0] ic_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_ins;
  logic        id_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .trap       (trap),
    .pr_miss    (pr_miss),
    .jalr_taken (jalr_taken),
    .pc_stall   (pc_stall),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_gnt     (ic_gnt),
    .ic_rvalid  (ic_rvalid),
    .ic_rdata   (ic_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_ins     (if_ins),
    .id_ready   (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven for the following edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL rst_ic_req: got %0b want 0", ic_req); end
    tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL rst_pc_stall: got %0b want 1", pc_stall); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_if_valid: got %0b want 0", if_valid); end
    tests_run++; if (if_pc !== 64'h0) begin tests_failed++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    tests_run++; if (if_ins !== 32'h0) begin tests_failed++; $display("FAIL rst_if_ins: got %h want 0", if_ins); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL idle_ic_req: got %0b want 0", ic_req); end
    tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL idle_pc_stall: got %0b want 1", pc_stall); end
    cyc();
    ic_gnt = 1'b1;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %0b want 1", ic_req); end
    tests_run++; if (ic_addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL first_addr: got %h want 80000000", ic_addr); end
    tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL first_req_stall: got %0b want 1", pc_stall); end
    cyc();
    ic_gnt = 1'b0; ic_rvalid = 1'b1; ic_rdata = 32'h0000_0013;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL wait_ic_req: got %0b want 0", ic_req); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_if_valid: got %0b want 0", if_valid); end
    tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL wait_pc_stall: got %0b want 1", pc_stall); end
    cyc();
    ic_rvalid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL first_if_valid: got %0b want 1", if_valid); end
    tests_run++; if (if_pc !== 64'h8000_0000) begin tests_failed++; $display("FAIL first_if_pc: got %h want 80000000", if_pc); end
    tests_run++; if (if_ins !== 32'h0000_0013) begin tests_failed++; $display("FAIL first_if_ins: got %h want 00000013", if_ins); end
    tests_run++; if (pc_stall !== 1'b0) begin tests_failed++; $display("FAIL handoff_stall: got %0b want 0", pc_stall); end
    cyc();
    id_ready = 1'b0; pc = 64'h8000_0004;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL after_handoff_valid: got %0b want 0", if_valid); end
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL next_req: got %0b want 1", ic_req); end
    tests_run++; if (ic_addr !== 64'h8000_0004) begin tests_failed++; $display("FAIL next_addr: got %h want 80000004", ic_addr); end
    tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL next_req_stall: got %0b want 1", pc_stall); end
  endtask

  task automatic test_backpressure();
    ic_gnt = 1'b1;
    cyc();
    ic_gnt = 1'b0; ic_rvalid = 1'b1; ic_rdata = 32'h00a0_0093;
    cyc();
    ic_rvalid = 1'b0; id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, if_valid); end
      tests_run++; if (if_pc !== 64'h8000_0004) begin tests_failed++; $display("FAIL bp_if_pc[%0d]: got %h want 80000004", i, if_pc); end
      tests_run++; if (if_ins !== 32'h00a0_0093) begin tests_failed++; $display("FAIL bp_if_ins[%0d]: got %h want 00a00093", i, if_ins); end
      tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL bp_stall[%0d]: got %0b want 1", i, pc_stall); end
      cyc();
    end
    id_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (pc_stall !== 1'b0) begin tests_failed++; $display("FAIL bp_release_stall: got %0b want 0", pc_stall); end
    tests_run++; if (if_ins !== 32'h00a0_0093) begin tests_failed++; $display("FAIL bp_release_ins: got %h want 00a00093", if_ins); end
    cyc();
    id_ready = 1'b0; pc = 64'h8000_0008;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_after_valid: got %0b want 0", if_valid); end
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL bp_after_req: got %0b want 1", ic_req); end
  endtask

  task automatic test_pr_miss_wait();
    ic_gnt = 1'b1;
    cyc();
    ic_gnt = 1'b0; pr_miss = 1'b1;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL prm_wait_req: got %0b want 0", ic_req); end
    cyc();
    pr_miss = 1'b0; pc = 64'h8000_0200;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL prm_discard_req: got %0b want 0", ic_req); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL prm_discard_valid: got %0b want 0", if_valid); end
    cyc();
    ic_rvalid = 1'b1; ic_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL prm_stale_req: got %0b want 0", ic_req); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL prm_stale_valid: got %0b want 0", if_valid); end
    cyc();
    ic_rvalid = 1'b0;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL prm_new_req: got %0b want 1", ic_req); end
    tests_run++; if (ic_addr !== 64'h8000_0200) begin tests_failed++; $display("FAIL prm_new_addr: got %h want 80000200", ic_addr); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL prm_new_valid: got %0b want 0", if_valid); end
    ic_gnt = 1'b1;
    cyc();
    ic_gnt = 1'b0; ic_rvalid = 1'b1; ic_rdata = 32'h1111_1111;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL prm_wait2_valid: got %0b want 0", if_valid); end
    cyc();
    ic_rvalid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL prm_fetch_valid: got %0b want 1", if_valid); end
    tests_run++; if (if_ins !== 32'h1111_1111) begin tests_failed++; $display("FAIL prm_fetch_ins: got %h want 11111111", if_ins); end
    tests_run++; if (if_pc !== 64'h8000_0200) begin tests_failed++; $display("FAIL prm_fetch_pc: got %h want 80000200", if_pc); end
    cyc();
    id_ready = 1'b0; pc = 64'h8000_0204;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL prm_end_req: got %0b want 1", ic_req); end
  endtask

  task automatic test_trap_gnt();
    ic_gnt = 1'b1; trap = 1'b1;
    cyc();
    ic_gnt = 1'b0; trap = 1'b0; pc = 64'h8000_0100;
    ic_rvalid = 1'b1; ic_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL trap_discard_req: got %0b want 0", ic_req); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL trap_discard_valid: got %0b want 0", if_valid); end
    cyc();
    ic_rvalid = 1'b0;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL trap_new_req: got %0b want 1", ic_req); end
    tests_run++; if (ic_addr !== 64'h8000_0100) begin tests_failed++; $display("FAIL trap_new_addr: got %h want 80000100", ic_addr); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL trap_new_valid: got %0b want 0", if_valid); end
    cyc();
    pc = 64'h8000_0103; ic_rvalid = 1'b1;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL req_hold_req: got %0b want 1", ic_req); end
    tests_run++; if (ic_addr !== 64'h8000_0102) begin tests_failed++; $display("FAIL req_odd_addr: got %h want 80000102", ic_addr); end
    tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL req_hold_stall: got %0b want 1", pc_stall); end
    cyc();
    ic_rvalid = 1'b0; pc = 64'h8000_0100;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL req_stray_rvalid: got %0b want 1", ic_req); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL req_stray_valid: got %0b want 0", if_valid); end
  endtask

  task automatic test_jalr_valid();
    ic_gnt = 1'b1;
    cyc();
    ic_gnt = 1'b0; ic_rvalid = 1'b1; ic_rdata = 32'h0000_80e7;
    cyc();
    ic_rvalid = 1'b0; jalr_taken = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL jalr_valid: got %0b want 1", if_valid); end
    tests_run++; if (if_pc !== 64'h8000_0100) begin tests_failed++; $display("FAIL jalr_if_pc: got %h want 80000100", if_pc); end
    tests_run++; if (if_ins !== 32'h0000_80e7) begin tests_failed++; $display("FAIL jalr_if_ins: got %h want 000080e7", if_ins); end
    cyc();
    jalr_taken = 1'b0; id_ready = 1'b0; pc = 64'h8000_0400;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL jalr_after_valid: got %0b want 0", if_valid); end
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL jalr_new_req: got %0b want 1", ic_req); end
    tests_run++; if (ic_addr !== 64'h8000_0400) begin tests_failed++; $display("FAIL jalr_new_addr: got %h want 80000400", ic_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    ic_gnt = 1'b1;
    cyc();
    ic_gnt = 1'b0;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL mid_wait_req: got %0b want 0", ic_req); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_req: got %0b want 0", ic_req); end
    tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_stall: got %0b want 1", pc_stall); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %0b want 0", if_valid); end
    tests_run++; if (if_pc !== 64'h0) begin tests_failed++; $display("FAIL mid_rst_if_pc: got %h want 0", if_pc); end
    tests_run++; if (if_ins !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_if_ins: got %h want 0", if_ins); end
    pc = 64'h8000_0000;
    cyc();
    ic_rvalid = 1'b1; ic_rdata = 32'hDEAD_BEEF;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_idle_valid: got %0b want 0", if_valid); end
    tests_run++; if (ic_req !== 1'b0) begin tests_failed++; $display("FAIL mid_idle_req: got %0b want 0", ic_req); end
    cyc();
    ic_rvalid = 1'b0;
    @(negedge clk);
    tests_run++; if (ic_req !== 1'b1) begin tests_failed++; $display("FAIL mid_reissue_req: got %0b want 1", ic_req); end
    tests_run++; if (ic_addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL mid_reissue_addr: got %h want 80000000", ic_addr); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_reissue_valid: got %0b want 0", if_valid); end
    ic_gnt = 1'b1;
    cyc();
    ic_gnt = 1'b0; ic_rvalid = 1'b1; ic_rdata = 32'h0000_0013;
    cyc();
    ic_rvalid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_refetch_valid: got %0b want 1", if_valid); end
    tests_run++; if (if_pc !== 64'h8000_0000) begin tests_failed++; $display("FAIL mid_refetch_pc: got %h want 80000000", if_pc); end
    tests_run++; if (if_ins !== 32'h0000_0013) begin tests_failed++; $display("FAIL mid_refetch_ins: got %h want 00000013", if_ins); end
    cyc();
    id_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    pc         = 64'h8000_0000;
    trap       = 1'b0;
    pr_miss    = 1'b0;
    jalr_taken = 1'b0;
    ic_gnt     = 1'b0;
    ic_rvalid  = 1'b0;
    ic_rdata   = 32'h0;
    id_ready   = 1'b0;

    test_reset();
    test_backpressure();
    test_pr_miss_wait();
    test_trap_gnt();
    test_jalr_valid();
    test_reset_mid_fetch();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the hart's program-counter register and instruction-fetch port. It stalls the PC while a fetch is in flight and issues one I-cache request per PC value. It hands each fetched word to decode over a valid/ready handshake and discards responses made stale by a redirect (trap, branch mispredict, jalr). At most one I-cache request is outstanding at any time.

## Interface

Parameters: none.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pc  in  64  current PC register value
- trap  in  1  trap redirect; PC loads trap_addr next edge regardless of stall
- pr_miss  in  1  branch-mispredict redirect; unconditional, like trap
- jalr_taken  in  1  jalr redirect; unconditional, like trap
- pc_stall  out  1  hold PC (sequential, jal and predicted-taken updates only)
- ic_req  out  1  I-cache fetch request
- ic_addr  out  64  fetch address, {pc[63:1],1'b0}
- ic_gnt  in  1  I-cache accepted request this cycle
- ic_rvalid  in  1  fetch data valid; earliest one cycle after ic_gnt
- ic_rdata  in  32  fetched word; may be a 16-bit instruction in [15:0]
- if_valid  out  1  instruction available to decode
- if_pc  out  64  PC of if_ins
- if_ins  out  32  fetched instruction word
- id_ready  in  1  decode accepts if_ins this cycle

## Operation

- redirect = trap | pr_miss | jalr_taken.
- Reset values:
  - state = REQ_IDLE.
  - ic_req = 0.
  - pc_stall = 1.
  - if_valid = 0.
  - if_pc = 0, if_ins = 0, req_pc = 0.
- States:
  - IDLE: only in the first cycle after rst_n deasserts. Always goes to REQ.
  - REQ: ic_req = 1, ic_addr from pc.
    - ic_gnt and !redirect: capture req_pc = pc, go to WAIT.
    - ic_gnt and redirect: go to DISCARD, because the granted address is stale.
    - !ic_gnt: stay in REQ. The address tracks pc, so it changes after a redirect. The I-cache permits the address to change before grant.
  - WAIT: ic_req = 0.
    - ic_rvalid and !redirect: load if_ins = ic_rdata and if_pc = req_pc, go to VALID.
    - ic_rvalid and redirect: drop the data, go to REQ.
    - redirect without ic_rvalid: go to DISCARD.
  - DISCARD: ic_req = 0, if_valid = 0. On ic_rvalid, drop the data and go to REQ. A redirect while in DISCARD does not change state.
  - VALID: if_valid = 1.
    - redirect: if_valid falls next cycle, go to REQ. id_ready is ignored in that cycle.
    - id_ready: handoff; go to REQ.
    - otherwise: hold, with if_pc and if_ins stable.
- pc_stall:
  - VALID: pc_stall = !id_ready. PC advances exactly in the handoff cycle; decode supplies c_ins, jal and predicted-taken that same cycle.
  - All other states: pc_stall = 1.
- ic_gnt outside REQ and ic_rvalid outside WAIT/DISCARD are protocol violations and are ignored.
- Outputs if_pc and if_ins are registered. pc_stall and ic_req are combinational from state and inputs.

## Timing

- Minimum loop: REQ+gnt (cycle 0), rvalid (cycle 1), VALID+id_ready (cycle 2), REQ for the new PC (cycle 3). Peak rate is one instruction per 3 cycles.
- if_valid rises the cycle after ic_rvalid.
- After a redirect, REQ for the new PC is presented:
  - the next cycle, from REQ (no gnt), WAIT (with rvalid) or VALID;
  - the cycle after the stale rvalid, from DISCARD.
- No instruction fetched before a redirect ever reaches if_valid = 1 after the redirect.
- Reset mid-fetch: everything returns to reset values immediately. An in-flight I-cache response that arrives after reset is ignored, because state is IDLE or REQ.

## Structure

- State encodings (IDLE, REQ, WAIT, DISCARD, VALID; 3-bit) are localparams in the shared hart definitions header, so the hazard unit and trace logic decode the same values.
- Single flat module, with no sub-modules. The output buffer is part of the same always block as the state register.

## Test plan

- Reset release with pc = 0x80000000, gnt immediate, rvalid one cycle later with 0x00000013, id_ready = 1:
  - ic_addr = 0x80000000;
  - if_valid with if_pc = 0x80000000 and if_ins = 0x00000013 at cycle 3;
  - pc_stall = 0 only in that cycle.
- Decode backpressure: id_ready = 0 for 4 cycles in VALID. if_ins and if_pc are held and pc_stall = 1 throughout. The handoff happens on the first id_ready = 1.
- pr_miss asserted in WAIT, with rvalid two cycles later carrying 0xDEADBEEF:
  - state goes to DISCARD;
  - if_valid never rises for 0xDEADBEEF;
  - REQ is presented with the new pc the cycle after that rvalid.
- trap asserted in the same cycle as ic_gnt. The stale response is discarded and a new REQ is presented at trap_addr 0x80000100.
- jalr_taken in VALID with id_ready = 1. The instruction is not handed off: if_valid falls next cycle and the next REQ address equals jalr_addr.
- rst_n pulsed low while in WAIT:
  - all outputs take their reset values asynchronously;
  - a later rvalid does not produce if_valid;
  - REQ is re-issued at 0x80000000.
